prog_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the multicycle core.
- Accepts a byte stream (length header, program words, XOR checksum), assembles little-endian 32-bit words and writes them into instruction memory through a write port.
- On a valid checksum it releases the core from reset and pulses the core's `start` input.
- The core is held in reset for the whole load, so it never fetches a partially written program.

---
 rtl/prog_loader.sv | 157 +++++++++++++++
 tb/tb_prog_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: consumes a length/words/checksum byte stream, writes
// little-endian 32-bit words into instruction memory, then releases the core.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  output logic              start,
  output logic              loaded,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt,
  output logic [2:0]        state_dbg
);

  // Byte stream handshake: a byte transfers on a rising edge where
  // in_valid & in_ready are both high; in_ready never depends on in_valid.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    CHK   = 3'd3,
    START = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

  state_t          state;
  state_t          state_n;
  logic [1:0]      byte_cnt;
  logic [23:0]     word_buf;
  logic [31:0]     chk;
  logic [ADDR_W:0] len;

  logic            accept;
  logic            word_done;
  logic [31:0]     word;
  logic [ADDR_W:0] cnt_inc;
  logic            hdr_ok;
  logic            clr;
  logic            wr;
  logic            ready_n;
  logic            start_n;
  logic            core_rst_n_n;
  logic            loaded_n;
  logic            err_n;

  assign accept    = in_valid & in_ready;
  assign word_done = accept & (byte_cnt == 2'd3);
  assign word      = {in_data, word_buf};
  assign cnt_inc   = word_cnt + 1'b1;
  assign hdr_ok    = (word[31:ADDR_W+1] == '0) && (word[ADDR_W:0] != '0) &&
                     (word[ADDR_W:0] <= DEPTH_W);
  assign state_dbg = state;

  always_comb begin
    state_n = state;
    clr     = 1'b0;
    wr      = 1'b0;
    case (state)
      IDLE: begin
        if (load_en) begin
          state_n = HDR;
          clr     = 1'b1;
        end
      end
      HDR:  if (word_done) state_n = hdr_ok ? DATA : ERR;
      DATA: begin
        // The word_cnt != len guard keeps the counter saturated at len.
        if (word_done && (word_cnt != len)) begin
          wr = 1'b1;
          if (cnt_inc == len) state_n = CHK;
        end
      end
      CHK:   if (word_done) state_n = (word == chk) ? START : ERR;
      START: state_n = DONE;
      DONE:  if (reload) state_n = IDLE;
      ERR:   if (reload) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Flag outputs are registered copies of the decode of the next state.
    ready_n      = (state_n == HDR) || (state_n == DATA) || (state_n == CHK);
    start_n      = (state_n == START);
    core_rst_n_n = (state_n == START) || (state_n == DONE);
    loaded_n     = (state_n == DONE);
    err_n        = (state_n == ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      start      <= 1'b0;
      core_rst_n <= 1'b0;
      loaded     <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      in_ready   <= ready_n;
      start      <= start_n;
      core_rst_n <= core_rst_n_n;
      loaded     <= loaded_n;
      err        <= err_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt  <= 2'd0;
      word_buf  <= 24'd0;
      chk       <= 32'd0;
      len       <= '0;
      word_cnt  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
    end else begin
      mem_we <= wr;
      if (clr) begin
        byte_cnt <= 2'd0;
        chk      <= 32'd0;
        word_cnt <= '0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (accept) begin
        case (byte_cnt)
          2'd0:    word_buf[7:0]   <= in_data;
          2'd1:    word_buf[15:8]  <= in_data;
          2'd2:    word_buf[23:16] <= in_data;
          default: ;
        endcase
      end
      if ((state == HDR) && word_done && hdr_ok) len <= word[ADDR_W:0];
      if (wr) begin
        mem_addr  <= word_cnt[ADDR_W-1:0];
        mem_wdata <= word;
        chk       <= chk ^ word;
        word_cnt  <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: a transaction-level model of each load
// predicts writes, word count and the start/done/err flags cycle by cycle.
module tb_prog_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_START = 2;
  localparam int P_DONE  = 3;
  localparam int P_ERR   = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_en = 1'b0;
  logic              reload = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst_n;
  logic              start;
  logic              loaded;
  logic              err;
  logic [ADDR_W:0]   word_cnt;
  logic [2:0]        state_dbg;

  prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .reload(reload),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .start(start), .loaded(loaded), .err(err),
    .word_cnt(word_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int phase = P_IDLE;
  int exp_wc = 0;
  logic [39:0] exp_q[$];
  int rd_idx = 0;
  logic [31:0] prog[0:DEPTH-1];
  logic [31:0] obs_data[0:DEPTH-1];
  logic [7:0]  last_addr = 8'd0;
  int n_wr = 0;
  int n_start = 0;
  int base_wr = 0;
  int base_start = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle the DUT outputs must match the load model.
  always @(negedge clk) begin
    logic pend;
    pend = (exp_q.size() > rd_idx);
    check("in_ready", in_ready, phase == P_LOAD);
    check("start", start, phase == P_START);
    check("core_rst_n", core_rst_n, (phase == P_START) || (phase == P_DONE));
    check("loaded", loaded, phase == P_DONE);
    check("err", err, phase == P_ERR);
    check("word_cnt", word_cnt, exp_wc);
    check("mem_we", mem_we, pend);
    if (mem_we && pend) check("mem_write", {mem_addr, mem_wdata}, exp_q[rd_idx]);
    if (pend) rd_idx++;
    if (mem_we) begin
      n_wr++;
      last_addr = mem_addr;
      obs_data[mem_addr] = mem_wdata;
    end
    if (start) n_start++;
  end

  function automatic logic [31:0] xor_of(input int n);
    logic [31:0] x = 32'd0;
    for (int i = 0; i < n; i++) x ^= prog[i];
    return x;
  endfunction

  task automatic begin_load();
    load_en  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(posedge clk); #1;
    phase      = P_LOAD;
    exp_wc     = 0;
    in_valid   = 1'b0;
    base_wr    = n_wr;
    base_start = n_start;
  endtask

  task automatic send_byte(input logic [7:0] b, input int vpct, output bit ok);
    bit v;
    logic rdy;
    ok = 1'b0;
    for (int t = 0; t < 400; t++) begin
      v        = ($urandom_range(1, 100) <= vpct);
      rdy      = in_ready;
      in_valid = v;
      in_data  = v ? b : 8'($urandom);
      reload   = ($urandom_range(0, 19) == 0);
      load_en  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (v && rdy) begin
        ok       = 1'b1;
        in_valid = 1'b0;
        reload   = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    reload   = 1'b0;
    check("byte_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    phase    = P_IDLE;
    exp_wc   = 0;
    load_en  = 1'b0;
    reload   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_state_idle", state_dbg, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic do_reload();
    load_en  = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    repeat (2) begin @(posedge clk); #1; end
    reload = 1'b1;
    @(posedge clk); #1;
    reload   = 1'b0;
    in_valid = 1'b0;
    phase    = P_IDLE;
  endtask

  task automatic run_load(input logic [31:0] hdr, input int n, input bit bad_chk,
                          input int vpct, input int abort_words);
    bit ok;
    logic [31:0] x;
    logic [31:0] c;
    begin_load();
    for (int k = 0; k < 4; k++) begin
      send_byte(hdr[8*k +: 8], vpct, ok);
      if (!ok) return;
    end
    if (!((hdr >= 32'd1) && (hdr <= 32'(DEPTH)))) begin
      phase = P_ERR;
      return;
    end
    x = 32'd0;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(prog[j][8*k +: 8], vpct, ok);
        if (!ok) return;
      end
      x ^= prog[j];
      exp_q.push_back({8'(j), prog[j]});
      exp_wc = j + 1;
      if (abort_words == j + 1) begin
        load_en = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        do_reset();
        return;
      end
    end
    c = bad_chk ? (x ^ 32'd1) : x;
    for (int k = 0; k < 4; k++) begin
      send_byte(c[8*k +: 8], vpct, ok);
      if (!ok) return;
    end
    phase = (c == x) ? P_START : P_ERR;
    if (phase == P_START) begin
      @(posedge clk); #1;
      phase = P_DONE;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Directed program: three words, good then bad checksum.
    prog[0] = 32'h00000013;
    prog[1] = 32'h00100093;
    prog[2] = 32'h00208113;
    check("model_xor", xor_of(3), 32'h00308193);
    run_load(32'd3, 3, 1'b0, 100, 0);
    @(negedge clk);
    check("t2_loaded", loaded, 1'b1);
    check("t2_core_rst_n", core_rst_n, 1'b1);
    check("t2_start_pulses", n_start - base_start, 1);
    check("t2_writes", n_wr - base_wr, 3);
    check("t2_word1", obs_data[1], 32'h00100093);
    check("t2_word2", obs_data[2], 32'h00208113);
    do_reload();

    run_load(32'd3, 3, 1'b1, 100, 0);
    @(negedge clk);
    check("t3_err", err, 1'b1);
    check("t3_core_rst_n", core_rst_n, 1'b0);
    check("t3_start_pulses", n_start - base_start, 0);
    do_reload();
    @(negedge clk);
    check("t3_err_cleared", err, 1'b0);

    // Header rejections: zero, over-depth, nonzero upper bits.
    run_load(32'd0, 0, 1'b0, 80, 0);
    @(negedge clk);
    check("t4_n0_err", err, 1'b1);
    check("t4_n0_writes", n_wr - base_wr, 0);
    do_reload();
    run_load(32'd257, 0, 1'b0, 80, 0);
    @(negedge clk);
    check("t4_n257_err", err, 1'b1);
    check("t4_n257_writes", n_wr - base_wr, 0);
    do_reload();
    run_load(32'h00010003, 0, 1'b0, 80, 0);
    do_reload();

    // Asynchronous reset after two words, then a fresh load.
    for (int i = 0; i < 5; i++) prog[i] = $urandom;
    run_load(32'd5, 5, 1'b0, 70, 2);
    run_load(32'd4, 4, 1'b0, 70, 0);
    do_reload();

    // Gappy N=2 load.
    prog[0] = $urandom;
    prog[1] = $urandom;
    run_load(32'd2, 2, 1'b0, 40, 0);
    do_reload();

    // Full-depth load.
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    run_load(32'(DEPTH), DEPTH, 1'b0, 90, 0);
    @(negedge clk);
    check("t6_last_addr", last_addr, 8'hFF);
    check("t6_word_cnt", word_cnt, 9'd256);
    check("t6_writes", n_wr - base_wr, DEPTH);
    do_reload();

    // Random loads.
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      run_load(32'(n), n, ($urandom_range(0, 3) == 0), $urandom_range(30, 100), 0);
      do_reload();
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
